mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 10, maximum memory operations in flight (memory pipeline depth).
REQ-002 SHALL have parameter TAG_W, default 6, width of requester tags.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports reqN_valid / reqN_ready (N=0,1)  input / output  1 / 1  per-requester request handshake.
REQ-006 SHALL have ports reqN_addr, reqN_data  input  32 each  byte address; store data.
REQ-007 SHALL have ports reqN_bms, reqN_load  input  1 each  byte mode select; 1=load, 0=store.
REQ-008 SHALL have port reqN_tag  input  TAG_W  requester tag, returned with the response.
REQ-009 SHALL have ports mem_valid, mem_address, mem_store_value, mem_bms, mem_load_store  output  1/32/32/1/1  issue to memory.
REQ-010 SHALL have ports mem_rsp_valid, mem_rsp_value, mem_rsp_load  input  1/32/1  memory completion.
REQ-011 SHALL have ports rspN_valid, rspN_data, rspN_tag, rspN_load  output  1/32/TAG_W/1  completion routed to requester N.
REQ-012 SHALL have ports outstanding  output  clog2(MAX_OUTSTANDING+1)  in-flight count; err  output  1  sticky protocol error.

Function
REQ-013 SHALL accept at most one request per cycle; a transfer occurs when reqN_valid and reqN_ready are both high.
REQ-014 SHALL drive reqN_ready high only for the granted requester and only when the in-flight tracker is not full, or is full with a completion popping that same cycle.
REQ-015 SHALL present the accepted request on the mem_* outputs the cycle after acceptance, with mem_valid high for exactly one cycle; mem_store_value SHALL be 0 for loads.
REQ-016 SHALL drive mem_valid and all mem_* outputs to 0 in cycles with no issue.
REQ-017 SHALL push {requester id, tag, load flag} into an in-order tracker FIFO of depth MAX_OUTSTANDING on acceptance.
REQ-018 SHALL, on mem_rsp_valid, pop the FIFO head and assert rspN_valid for one cycle the next cycle to the recorded requester, with rspN_data = mem_rsp_value for loads and 0 for stores, and with rspN_tag and rspN_load from the entry.
REQ-019 SHALL keep non-selected rsp outputs at 0.
REQ-020 SHALL handle push and pop in the same cycle with outstanding unchanged, including when the FIFO is full.
REQ-021 SHALL wrap FIFO pointers modulo MAX_OUTSTANDING.
REQ-022 SHALL, on mem_rsp_valid with an empty FIFO or mem_rsp_load mismatching the head load flag, set err (sticky until reset), and SHALL NOT pop on empty.
REQ-023 SHALL, when neither request is valid, leave grant state unchanged.

Reset
REQ-024 SHALL, while reset is low, force all outputs to 0, empty the FIFO (outstanding=0), clear err, and point the round-robin pointer at requester 0.
REQ-025 SHALL discard all in-flight tracking on reset mid-operation; responses arriving after reset deassertion with an empty FIFO SHALL set err.

Configuration
REQ-026 SHALL, with MEM_ARB_RR_EN defined, use round-robin arbitration: the pointer moves to the other requester after each grant, and the pointer-side requester wins when both are valid.
REQ-027 SHALL, without MEM_ARB_RR_EN, use fixed priority with requester 0 always winning.

Verification
REQ-028 SHALL cover: req0 load addr 0x10 tag 3 alone -> mem_valid one cycle later with mem_address=0x10 and mem_load_store=1; memory response 0xCAFEBABE -> rsp0_valid with data 0xCAFEBABE and tag 3.
REQ-029 SHALL cover: both requesters valid for 4 cycles, RR enabled -> grants 0,1,0,1; RR disabled -> grants 0,0,0,0 and req1_ready stays 0.
REQ-030 SHALL cover: 10 accepted requests, no responses -> outstanding=10 and both ready signals 0; response plus new request in the same cycle -> accepted, outstanding stays 10.
REQ-031 SHALL cover: mem_rsp_valid with outstanding=0 -> err=1, outstanding stays 0; err holds until reset.
REQ-032 SHALL cover: reset asserted with 5 in flight -> all outputs 0 and outstanding=0 immediately (asynchronous).
REQ-033 SHALL cover: req1 store data 0x12345678 -> mem_store_value=0x12345678; its response -> rsp1_valid with rsp1_data=0 and rsp1_load=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter with an in-order completion tracker.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mem_port_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 10,
   parameter int unsigned TAG_W           = 6
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 req0_valid,
   output logic                                 req0_ready,
   input  logic [31:0]                          req0_addr,
   input  logic [31:0]                          req0_data,
   input  logic                                 req0_bms,
   input  logic                                 req0_load,
   input  logic [TAG_W-1:0]                     req0_tag,
   input  logic                                 req1_valid,
   output logic                                 req1_ready,
   input  logic [31:0]                          req1_addr,
   input  logic [31:0]                          req1_data,
   input  logic                                 req1_bms,
   input  logic                                 req1_load,
   input  logic [TAG_W-1:0]                     req1_tag,
   output logic                                 mem_valid,
   output logic [31:0]                          mem_address,
   output logic [31:0]                          mem_store_value,
   output logic                                 mem_bms,
   output logic                                 mem_load_store,
   input  logic                                 mem_rsp_valid,
   input  logic [31:0]                          mem_rsp_value,
   input  logic                                 mem_rsp_load,
   output logic                                 rsp0_valid,
   output logic [31:0]                          rsp0_data,
   output logic [TAG_W-1:0]                     rsp0_tag,
   output logic                                 rsp0_load,
   output logic                                 rsp1_valid,
   output logic [31:0]                          rsp1_data,
   output logic [TAG_W-1:0]                     rsp1_tag,
   output logic                                 rsp1_load,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                                 err
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef struct packed {
      logic             id;
      logic [TAG_W-1:0] tag;
      logic             load;
   } trk_t;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   trk_t [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic                       err_q, err_d;

   logic                       mem_valid_q, mem_valid_d;
   logic [31:0]                mem_address_q, mem_address_d;
   logic [31:0]                mem_store_value_q, mem_store_value_d;
   logic                       mem_bms_q, mem_bms_d;
   logic                       mem_load_store_q, mem_load_store_d;

   logic                       rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
   logic [31:0]                rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
   logic [TAG_W-1:0]           rsp0_tag_q, rsp0_tag_d, rsp1_tag_q, rsp1_tag_d;
   logic                       rsp0_load_q, rsp0_load_d, rsp1_load_q, rsp1_load_d;

   logic                       grant_any, grant_id;
   logic                       full_c, empty_c, pop_c, can_accept_c, push_c;
   logic [31:0]                sel_addr, sel_data;
   logic                       sel_bms, sel_load;
   logic [TAG_W-1:0]           sel_tag;
   trk_t                       head_c;

`ifdef MEM_ARB_RR_EN
   logic rr_ptr_q, rr_ptr_d;

   // Pointer hands priority to the other requester after every accepted grant.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (push_c) rr_ptr_d = ~grant_id;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rr_ptr_q <= 1'b0;
      else        rr_ptr_q <= rr_ptr_d;
   end
`endif

   always_comb begin
      grant_any = req0_valid | req1_valid;
`ifdef MEM_ARB_RR_EN
      grant_id  = (req0_valid & req1_valid) ? rr_ptr_q : ~req0_valid;
`else
      grant_id  = ~req0_valid;
`endif
   end

   // A full tracker still accepts when the head retires in the same cycle.
   assign full_c       = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign empty_c      = (count_q == '0);
   assign pop_c        = mem_rsp_valid & ~empty_c;
   assign can_accept_c = reset & (~full_c | mem_rsp_valid);
   assign req0_ready   = can_accept_c & grant_any & ~grant_id;
   assign req1_ready   = can_accept_c & grant_any & grant_id;
   assign push_c       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign head_c       = fifo_q[rd_ptr_q];

   always_comb begin
      sel_addr = grant_id ? req1_addr : req0_addr;
      sel_data = grant_id ? req1_data : req0_data;
      sel_bms  = grant_id ? req1_bms  : req0_bms;
      sel_load = grant_id ? req1_load : req0_load;
      sel_tag  = grant_id ? req1_tag  : req0_tag;
   end

   always_comb begin
      fifo_d            = fifo_q;
      wr_ptr_d          = wr_ptr_q;
      rd_ptr_d          = rd_ptr_q;
      err_d             = err_q;
      mem_valid_d       = 1'b0;
      mem_address_d     = '0;
      mem_store_value_d = '0;
      mem_bms_d         = 1'b0;
      mem_load_store_d  = 1'b0;
      rsp0_valid_d      = 1'b0;
      rsp0_data_d       = '0;
      rsp0_tag_d        = '0;
      rsp0_load_d       = 1'b0;
      rsp1_valid_d      = 1'b0;
      rsp1_data_d       = '0;
      rsp1_tag_d        = '0;
      rsp1_load_d       = 1'b0;

      if (push_c) begin
         fifo_d[wr_ptr_q]  = '{id: grant_id, tag: sel_tag, load: sel_load};
         wr_ptr_d          = ptr_inc(wr_ptr_q);
         mem_valid_d       = 1'b1;
         mem_address_d     = sel_addr;
         mem_store_value_d = sel_load ? 32'h0 : sel_data;
         mem_bms_d         = sel_bms;
         mem_load_store_d  = sel_load;
      end

      // Completions retire strictly in issue order; stray or mistyped ones latch err.
      if (mem_rsp_valid) begin
         if (empty_c) begin
            err_d = 1'b1;
         end else begin
            if (mem_rsp_load != head_c.load) err_d = 1'b1;
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (head_c.id) begin
               rsp1_valid_d = 1'b1;
               rsp1_data_d  = head_c.load ? mem_rsp_value : 32'h0;
               rsp1_tag_d   = head_c.tag;
               rsp1_load_d  = head_c.load;
            end else begin
               rsp0_valid_d = 1'b1;
               rsp0_data_d  = head_c.load ? mem_rsp_value : 32'h0;
               rsp0_tag_d   = head_c.tag;
               rsp0_load_d  = head_c.load;
            end
         end
      end

      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_q            <= '0;
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         count_q           <= '0;
         err_q             <= 1'b0;
         mem_valid_q       <= 1'b0;
         mem_address_q     <= '0;
         mem_store_value_q <= '0;
         mem_bms_q         <= 1'b0;
         mem_load_store_q  <= 1'b0;
         rsp0_valid_q      <= 1'b0;
         rsp0_data_q       <= '0;
         rsp0_tag_q        <= '0;
         rsp0_load_q       <= 1'b0;
         rsp1_valid_q      <= 1'b0;
         rsp1_data_q       <= '0;
         rsp1_tag_q        <= '0;
         rsp1_load_q       <= 1'b0;
      end else begin
         fifo_q            <= fifo_d;
         wr_ptr_q          <= wr_ptr_d;
         rd_ptr_q          <= rd_ptr_d;
         count_q           <= count_d;
         err_q             <= err_d;
         mem_valid_q       <= mem_valid_d;
         mem_address_q     <= mem_address_d;
         mem_store_value_q <= mem_store_value_d;
         mem_bms_q         <= mem_bms_d;
         mem_load_store_q  <= mem_load_store_d;
         rsp0_valid_q      <= rsp0_valid_d;
         rsp0_data_q       <= rsp0_data_d;
         rsp0_tag_q        <= rsp0_tag_d;
         rsp0_load_q       <= rsp0_load_d;
         rsp1_valid_q      <= rsp1_valid_d;
         rsp1_data_q       <= rsp1_data_d;
         rsp1_tag_q        <= rsp1_tag_d;
         rsp1_load_q       <= rsp1_load_d;
      end
   end

   assign mem_valid       = mem_valid_q;
   assign mem_address     = mem_address_q;
   assign mem_store_value = mem_store_value_q;
   assign mem_bms         = mem_bms_q;
   assign mem_load_store  = mem_load_store_q;
   assign rsp0_valid      = rsp0_valid_q;
   assign rsp0_data       = rsp0_data_q;
   assign rsp0_tag        = rsp0_tag_q;
   assign rsp0_load       = rsp0_load_q;
   assign rsp1_valid      = rsp1_valid_q;
   assign rsp1_data       = rsp1_data_q;
   assign rsp1_tag        = rsp1_tag_q;
   assign rsp1_load       = rsp1_load_q;
   assign outstanding     = count_q;
   assign err             = err_q;

endmodule
